// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types, PRBS31 constants and saturating add for the RX PRBS checker
package rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } rx_state_e;

  localparam int             PRBS_W     = 31;
  localparam int             PRBS_TAP_A = 30;
  localparam int             PRBS_TAP_B = 27;
  localparam logic [30:0]    PRBS_ONES  = '1;

  // Adds inc to a w-bit counter held in 64 bits, clamping at the w-bit all-ones value.
  function automatic logic [63:0] sat_inc(input logic [63:0] a, input logic [63:0] inc,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum   = {1'b0, a} + {1'b0, inc};
    if (sum > {1'b0, max_v}) return max_v;
    return sum[63:0];
  endfunction

endpackage

// File: rtl/prbs_word_gen.sv
// rtl/prbs_word_gen.sv - PRBS31 LFSR producing one DATA_W-bit expected word per advance
module prbs_word_gen
  import rx_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                advance_i,
  input  logic [PRBS_W-1:0]   seed_i,
  output logic [DATA_W-1:0]   word_o,
  output logic [PRBS_W-1:0]   next_state_o
);

  logic [PRBS_W-1:0] state_q;
  logic [PRBS_W-1:0] seed_fix;
  logic [PRBS_W-1:0] base;
  logic [PRBS_W-1:0] walk;
  logic              fb;

  // An all-zero LFSR never leaves zero, so a zero seed is replaced.
  assign seed_fix = (seed_i == '0) ? PRBS_ONES : seed_i;

  always_comb begin
    base   = load_i ? seed_fix : state_q;
    walk   = base;
    fb     = 1'b0;
    word_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      fb                  = walk[PRBS_TAP_A] ^ walk[PRBS_TAP_B];
      word_o[DATA_W-1-i]  = fb;
      walk                = {walk[PRBS_W-2:0], fb};
    end
    next_state_o = walk;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PRBS_ONES;
    end else if (advance_i) begin
      state_q <= next_state_o;
    end else if (load_i) begin
      state_q <= base;
    end
  end

endmodule

// File: rtl/rx_prbs_checker.sv
// rtl/rx_prbs_checker.sv - PRBS31 stream checker with lock FSM and counters; RX_FRAME_CHECK_EN adds o_frame_err_cnt
module rx_prbs_checker
  import rx_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  input  logic                i_rx_enable,
  input  logic [30:0]         i_prbs_seed,
  input  logic                i_cnt_clear,
  output logic                s_axis_tready,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_sof,
  input  logic                s_axis_eof,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  output logic [1:0]          o_state,
  output logic                o_locked,
  output logic [CNT_W-1:0]    o_err_bit_cnt,
  output logic [CNT_W-1:0]    o_word_cnt
`ifdef RX_FRAME_CHECK_EN
  ,
  output logic [CNT_W-1:0]    o_frame_err_cnt
`endif
);

  localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int POP_W   = $clog2(DATA_W + 1);

  logic              en_q;
  rx_state_e         state_q, state_d;
  logic              armed_q, armed_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              v1_q, v1_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  word_q, word_d;

  logic              accept, cmp_state, do_cmp, upd, errored;
  logic [POP_W-1:0]  pop;
  logic [DATA_W-1:0] exp_word;
  logic [30:0]       prbs_next_unused;

  assign accept    = s_axis_tvalid && en_q;
  assign cmp_state = (state_q == ST_SEARCH) || (state_q == ST_LOCKED);
  // Once a sof has been seen in SEARCH/LOCKED every accepted beat is compared.
  assign do_cmp    = accept && cmp_state && (armed_q || s_axis_sof);
  assign upd       = v1_q && en_q && cmp_state;
  assign errored   = |xor_q;

  prbs_word_gen #(.DATA_W(DATA_W)) u_gen (
    .clk_i        (s_axi_aclk),
    .rst_i        (s_axi_areset),
    .load_i       (do_cmp && s_axis_sof),
    .advance_i    (do_cmp),
    .seed_i       (i_prbs_seed),
    .word_o       (exp_word),
    .next_state_o (prbs_next_unused)
  );

  always_comb begin
    xor_d = s_axis_tdata ^ exp_word;
    v1_d  = do_cmp;
    pop   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pop = pop + POP_W'(xor_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    run_d   = run_q;
    if (do_cmp && s_axis_sof) armed_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        armed_d = 1'b0;
        run_d   = '0;
        if (en_q) state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (upd) begin
          if (errored) begin
            run_d = '0;
          end else if (int'(run_q) + 1 >= LOCK_CNT) begin
            state_d = ST_LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (upd) begin
          if (!errored) begin
            run_d = '0;
          end else if (int'(run_q) + 1 >= UNLOCK_CNT) begin
            state_d = ST_LOST;
            run_d   = '0;
            armed_d = 1'b0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
        armed_d = 1'b0;
        run_d   = '0;
      end
    endcase
    if (!en_q) begin
      state_d = ST_IDLE;
      armed_d = 1'b0;
      run_d   = '0;
    end
  end

  always_comb begin
    err_d  = err_q;
    word_d = word_q;
    if (upd) begin
      err_d  = CNT_W'(sat_inc(64'(err_q), 64'(pop), CNT_W));
      word_d = CNT_W'(sat_inc(64'(word_q), 64'd1, CNT_W));
    end
    if (i_cnt_clear) begin
      err_d  = '0;
      word_d = '0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      en_q    <= 1'b0;
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      run_q   <= '0;
      xor_q   <= '0;
      v1_q    <= 1'b0;
      err_q   <= '0;
      word_q  <= '0;
    end else begin
      en_q    <= i_rx_enable;
      state_q <= state_d;
      armed_q <= armed_d;
      run_q   <= run_d;
      xor_q   <= xor_d;
      v1_q    <= v1_d;
      err_q   <= err_d;
      word_q  <= word_d;
    end
  end

  assign s_axis_tready = en_q;
  assign o_state       = state_q;
  assign o_locked      = (state_q == ST_LOCKED);
  assign o_err_bit_cnt = err_q;
  assign o_word_cnt    = word_q;

`ifdef RX_FRAME_CHECK_EN
  logic             frame_open_q, frame_open_d;
  logic [CNT_W-1:0] ferr_q, ferr_d;

  // Framing violations: sof inside an open frame, or eof with no frame open.
  always_comb begin
    frame_open_d = frame_open_q;
    ferr_d       = ferr_q;
    if (accept) begin
      if ((s_axis_sof && frame_open_q) || (s_axis_eof && !s_axis_sof && !frame_open_q)) begin
        ferr_d = CNT_W'(sat_inc(64'(ferr_q), 64'd1, CNT_W));
      end
      if (s_axis_eof)      frame_open_d = 1'b0;
      else if (s_axis_sof) frame_open_d = 1'b1;
    end
    if (i_cnt_clear) ferr_d = '0;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      frame_open_q <= 1'b0;
      ferr_q       <= '0;
    end else begin
      frame_open_q <= frame_open_d;
      ferr_q       <= ferr_d;
    end
  end

  assign o_frame_err_cnt = ferr_q;
`else
  logic eof_unused;
  assign eof_unused = s_axis_eof;
`endif

endmodule

// File: tb/tb_rx_prbs_checker.sv
// tb/tb_rx_prbs_checker.sv - directed self-checking bench for rx_prbs_checker (32- and 64-bit instances)
module tb_rx_prbs_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, en64 = 1'b0;
  logic [30:0] seed = '0, seed64 = '0;
  logic        clr = 1'b0;
  logic        tvalid = 1'b0, sof = 1'b0, eof = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid64 = 1'b0, sof64 = 1'b0, eof64 = 1'b0;
  logic [63:0] tdata64 = '0;
  logic        tready, tready64, locked, locked64;
  logic [1:0]  state, state64;
  logic [31:0] errc, wordc, errc64, wordc64;
`ifdef RX_FRAME_CHECK_EN
  logic [31:0] fe, fe64;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [30:0] ref_s;
  logic [63:0] w;

  always #5 clk = ~clk;

  rx_prbs_checker u_dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .i_rx_enable(en), .i_prbs_seed(seed),
    .i_cnt_clear(clr), .s_axis_tready(tready), .s_axis_tvalid(tvalid),
    .s_axis_sof(sof), .s_axis_eof(eof), .s_axis_tdata(tdata),
    .o_state(state), .o_locked(locked), .o_err_bit_cnt(errc), .o_word_cnt(wordc)
`ifdef RX_FRAME_CHECK_EN
    , .o_frame_err_cnt(fe)
`endif
  );

  rx_prbs_checker #(.DATA_W(64)) u_dut64 (
    .s_axi_aclk(clk), .s_axi_areset(rst), .i_rx_enable(en64), .i_prbs_seed(seed64),
    .i_cnt_clear(clr), .s_axis_tready(tready64), .s_axis_tvalid(tvalid64),
    .s_axis_sof(sof64), .s_axis_eof(eof64), .s_axis_tdata(tdata64),
    .o_state(state64), .o_locked(locked64), .o_err_bit_cnt(errc64), .o_word_cnt(wordc64)
`ifdef RX_FRAME_CHECK_EN
    , .o_frame_err_cnt(fe64)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic ref_seed(input logic [30:0] sd);
    ref_s = (sd == '0) ? '1 : sd;
  endtask

  // Shift-in reference: after width steps the first bit produced sits at width-1.
  task automatic ref_word(input int width, output logic [63:0] wo);
    logic b;
    wo = '0;
    for (int i = 0; i < width; i++) begin
      b     = ref_s[30] ^ ref_s[27];
      wo    = {wo[62:0], b};
      ref_s = {ref_s[29:0], b};
    end
  endtask

  task automatic beat(input logic s, input logic e, input logic [31:0] d);
    tvalid = 1'b1; sof = s; eof = e; tdata = d;
    @(posedge clk); #1;
    tvalid = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  task automatic beat64(input logic s, input logic e, input logic [63:0] d);
    tvalid64 = 1'b1; sof64 = s; eof64 = e; tdata64 = d;
    @(posedge clk); #1;
    tvalid64 = 1'b0; sof64 = 1'b0; eof64 = 1'b0;
  endtask

  task automatic frame32(input logic [30:0] sd, input int n, input int lo, input int hi,
                         input logic [31:0] flip);
    logic [63:0] wl;
    ref_seed(sd);
    seed = sd;
    for (int i = 0; i < n; i++) begin
      ref_word(32, wl);
      beat(i == 0, i == n - 1, wl[31:0] ^ ((i >= lo && i <= hi) ? flip : 32'h0));
    end
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_tready", tready, 0);
    check("rst_state", state, 0);
    check("rst_locked", locked, 0);
    check("rst_err", errc, 0);
    check("rst_word", wordc, 0);

    en = 1'b1; en64 = 1'b1;
    check("tready_before_latency", tready, 0);
    @(posedge clk); #1;
    check("tready_after_1cyc", tready, 1);
    check("state_idle_still", state, 0);
    @(posedge clk); #1;
    check("state_search", state, 1);

    // 64-word frame seeded 0x1
    ref_seed(31'h1);
    seed = 31'h1;
    for (int i = 0; i < 64; i++) begin
      ref_word(32, w);
      beat(i == 0, i == 63, w[31:0]);
      if (i == 3) check("search_before_lock", state, 1);
      if (i == 4) begin
        check("locked_after_4", state, 2);
        check("word_at_lock", wordc, 4);
      end
    end
    @(posedge clk); #1;
    check("t1_word", wordc, 64);
    check("t1_err", errc, 0);
    check("t1_locked", locked, 1);

    pulse_clear();
    check("clr_word", wordc, 0);
    check("clr_err", errc, 0);

    // single word with two flipped bits while locked
    frame32(31'h1234567, 20, 10, 10, 32'h0000_0005);
    @(posedge clk); #1;
    check("t2_err", errc, 2);
    check("t2_word", wordc, 20);
    check("t2_state", state, 2);

    // four fully inverted words drop the lock
    pulse_clear();
    frame32(31'h55, 8, 4, 7, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("t3_lost", state, 3);
    check("t3_err", errc, 128);
    check("t3_word", wordc, 8);
    @(posedge clk); #1;
    check("t3_search", state, 1);
    beat(1'b0, 1'b0, 32'hDEAD_BEEF);
    beat(1'b0, 1'b0, 32'h0123_4567);
    beat(1'b0, 1'b0, 32'h89AB_CDEF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t3_nosof_word", wordc, 8);
    check("t3_nosof_state", state, 1);
    frame32(31'h2, 6, -1, -1, 32'h0);
    @(posedge clk); #1;
    check("t3_relock_state", state, 2);
    check("t3_relock_word", wordc, 14);
    check("t3_relock_err", errc, 128);

`ifdef RX_FRAME_CHECK_EN
    pulse_clear();
    check("fe_clr", fe, 0);
    seed = 31'h3;
    ref_seed(31'h3); ref_word(32, w); beat(1'b1, 1'b0, w[31:0]);
    ref_seed(31'h3); ref_word(32, w); beat(1'b1, 1'b0, w[31:0]);
    ref_word(32, w); beat(1'b0, 1'b1, w[31:0]);
    ref_word(32, w); beat(1'b0, 1'b1, w[31:0]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("fe_count", fe, 2);
    check("fe_words", wordc, 4);
`endif

    // drop enable mid-frame with a clear colliding with an increment
    ref_seed(31'h7);
    seed = 31'h7;
    for (int i = 0; i < 7; i++) begin
      ref_word(32, w);
      if (i == 6) begin
        en  = 1'b0;
        clr = 1'b1;
      end
      beat(i == 0, 1'b0, w[31:0]);
    end
    clr = 1'b0;
    check("t5_tready_fell", tready, 0);
    check("t5_clr_err", errc, 0);
    check("t5_clr_word", wordc, 0);
    check("t5_state_lag", state, 2);
    @(posedge clk); #1;
    check("t5_idle", state, 0);
    check("t5_flushed_word", wordc, 0);
    check("t5_flushed_err", errc, 0);

    // 64-bit instance, zero seed
    check("t4_search", state64, 1);
    ref_seed(31'h0);
    seed64 = 31'h0;
    for (int i = 0; i < 16; i++) begin
      ref_word(64, w);
      beat64(i == 0, i == 15, w);
    end
    @(posedge clk); #1;
    check("t4_locked", locked64, 1);
    check("t4_err", errc64, 0);
    check("t4_word", wordc64, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_prbs_checker.md
Name: rx_prbs_checker

Overview:
Parametrised successor to the single-channel 32-bit stream receiver. Accepts an AXI-Stream word stream with sof/eof side-band and compares every accepted word against a locally generated PRBS31 sequence reseeded at each frame start. Runs a lock state machine and saturating error/word counters for the register block of the RX path. Configuration and status are plain ports; the AXI-Lite wrapper stays outside this block.

Parameters:
DATA_W, 32, stream word width; any multiple of 8, 8..128.
CNT_W, 32, width of the error and word counters, which saturate at all-ones.
LOCK_CNT, 4, consecutive error-free words needed to enter LOCKED; at least 1.
UNLOCK_CNT, 4, consecutive errored words in LOCKED that force LOST; at least 1.

Ports:
s_axi_aclk  in  1  sole clock.
s_axi_areset  in  1  synchronous reset, active-high.
i_rx_enable  in  1  receiver enable from the register block.
i_prbs_seed  in  31  LFSR seed; zero is replaced by all-ones.
i_cnt_clear  in  1  single-cycle pulse that clears the counters.
s_axis_tready  out  1  stream ready.
s_axis_tvalid  in  1  stream valid.
s_axis_sof  in  1  start of frame, qualified by the handshake.
s_axis_eof  in  1  end of frame, qualified by the handshake.
s_axis_tdata  in  DATA_W  stream data.
o_state  out  2  FSM state.
o_locked  out  1  high while the state is LOCKED.
o_err_bit_cnt  out  CNT_W  accumulated mismatched bits.
o_word_cnt  out  CNT_W  compared words.

Behaviour:
- Reset values: all outputs are 0 and the FSM is in IDLE.
- i_rx_enable is registered once. s_axis_tready equals the registered enable, so tready follows i_rx_enable with 1 cycle of latency and drops the same way.
- Beat accepted means tvalid && tready.
- LFSR step: b = s[30]^s[27]; s <= {s[29:0], b}.
- One word is DATA_W consecutive b values. The first value generated goes to bit DATA_W-1.
- The LFSR advances by one word per compared beat.
- On an accepted sof beat, the LFSR loads the seed and the expected word for that beat is the first word generated from the seed.
- Compare pipeline, stage 1: register xor = tdata ^ expected.
- Compare pipeline, stage 2: popcount, counter update and FSM update.
- Result: counters and state reflect a beat 2 cycles after acceptance.
- A beat is errored if its xor is non-zero.
- FSM encoding: IDLE=0, SEARCH=1, LOCKED=2, LOST=3.
- IDLE -> SEARCH when the registered enable is 1.
- SEARCH: ignore beats until an accepted sof. From then on, compare every beat. Count consecutive clean words; an errored word resets the run to 0. Enter LOCKED after LOCK_CNT clean words.
- LOCKED: count consecutive errored words; a clean word resets the run. Enter LOST after UNLOCK_CNT errored words.
- LOST: lasts 1 cycle, then goes to SEARCH and waits for the next sof.
- Any state -> IDLE when the registered enable is 0; the comparison pipeline is flushed.
- Counters update only for words that were actually compared, including in SEARCH after the sof. Both counters saturate.
- i_cnt_clear takes priority over a same-cycle increment; the counters read 0 the next cycle.
- sof and eof on the same beat form a one-word frame.
- sof arriving mid-frame reseeds.
- eof has no effect on the LFSR.
- Reset mid-frame returns to IDLE; the next frame requires a fresh sof.

Optional Feature:
RX_FRAME_CHECK_EN
- When defined: adds output o_frame_err_cnt [CNT_W-1:0], reset 0, saturating, cleared by i_cnt_clear.
- It increments on an accepted sof while a frame is open, or on an accepted eof while no frame is open.
- A frame opens on sof and closes on eof.
- When undefined: the port and the logic are absent, and sof/eof handling is otherwise identical.

Decomposition:
- Package rx_pkg holds:
  - the state enum (IDLE/SEARCH/LOCKED/LOST, 2 bits);
  - PRBS31 constants (taps 30/27, the all-ones replacement seed);
  - a saturating-increment function.
- Sub-module prbs_word_gen (parameter DATA_W): LFSR with load/advance inputs; it outputs the current expected word combinationally and the next state. It replaces the fixed 32-bit prbs generator on this path.

Test Plan:
- Reset, then enable=1, then a 64-word frame from a reference LFSR seeded 0x1 -> tready high 1 cycle after enable; LOCKED after 4 clean words; err_bit_cnt=0; word_cnt=64.
- Locked stream with word 10 xor 0x0000_0005 -> err_bit_cnt=2; state stays LOCKED.
- 4 consecutive words xor 0xFFFF_FFFF while LOCKED -> LOST for 1 cycle, then SEARCH; err_bit_cnt=128; no further comparison until a new sof re-locks.
- DATA_W=64, seed 0, 16-word frame -> the all-ones seed is used; lock reached; err_bit_cnt=0.
- Enable dropped mid-frame and i_cnt_clear pulsed on the same cycle as an increment -> IDLE; tready falls 1 cycle later; counters read 0.
- RX_FRAME_CHECK_EN, sequence sof, sof, eof, eof -> o_frame_err_cnt=2.
